// File: rtl/rx_tone_check_module.sv
`default_nettype none
// rx_tone_check_module: ADC loopback tone checker -- hysteresis rising crossings of I, peak |I|/|Q|, pass/fail.
// Revision 1.0
module rx_tone_check_module #(
  parameter int WIN_LEN    = 25000,
  parameter int SETTLE_LEN = 16,
  parameter int HYST       = 512,
  parameter int XING_TOL   = 2
) (
  input  logic        clk_msk_in,
  input  logic        logic_rst_n_in,
  input  logic        rx_in_valid,
  input  logic [15:0] rx_in_i,
  input  logic [15:0] rx_in_q,
  input  logic        check_start,
  input  logic [15:0] cfg_exp_xing,
  input  logic [15:0] cfg_amp_min,
  output logic        check_busy,
  output logic        check_done,
  output logic        check_pass,
  output logic [15:0] xing_count,
  output logic [15:0] peak_i,
  output logic [15:0] peak_q,
  output logic [63:0] debug_signal
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, MEASURE = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {H_UNK = 2'd0, H_NEG = 2'd1, H_POS = 2'd2} hyst_t;

  localparam logic [23:0]        SETTLE_LAST = 24'(SETTLE_LEN - 1);
  localparam logic [23:0]        WIN_LAST    = 24'(WIN_LEN - 1);
  localparam logic signed [15:0] HYST_P      = 16'(HYST);
  localparam logic signed [15:0] HYST_N      = -HYST_P;
  localparam logic [16:0]        TOL         = 17'(XING_TOL);

  state_t      state_q, state_d;
  hyst_t       hyst_q, hyst_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] xing_q, xing_d;
  logic [15:0] pki_q, pki_d;
  logic [15:0] pkq_q, pkq_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] amin_q, amin_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        smp_v_q;
  logic [15:0] smp_i_q, smp_q_q;

  logic [15:0]        mag_i, mag_q;
  logic signed [16:0] diff;
  logic [16:0]        adiff;
  logic               verdict;

  function automatic logic [15:0] mag16(input logic [15:0] x);
    logic [15:0] r;
    if (!x[15])             r = x;
    else if (x == 16'h8000) r = 16'h7FFF;
    else                    r = -x;
    return r;
  endfunction

  assign mag_i   = mag16(smp_i_q);
  assign mag_q   = mag16(smp_q_q);
  assign diff    = $signed({1'b0, xing_q}) - $signed({1'b0, exp_q});
  assign adiff   = diff[16] ? $unsigned(-diff) : $unsigned(diff);
  assign verdict = (adiff <= TOL) && (pki_q >= amin_q) && (pkq_q >= amin_q);

  // Input stage; a sample presented on the start edge belongs to no window.
  always_ff @(posedge clk_msk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      smp_v_q <= 1'b0;
      smp_i_q <= '0;
      smp_q_q <= '0;
    end else begin
      smp_v_q <= rx_in_valid && (state_q != IDLE);
      smp_i_q <= rx_in_i;
      smp_q_q <= rx_in_q;
    end
  end

  always_ff @(posedge clk_msk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      state_q <= IDLE;
      hyst_q  <= H_UNK;
      cnt_q   <= '0;
      xing_q  <= '0;
      pki_q   <= '0;
      pkq_q   <= '0;
      exp_q   <= '0;
      amin_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hyst_q  <= hyst_d;
      cnt_q   <= cnt_d;
      xing_q  <= xing_d;
      pki_q   <= pki_d;
      pkq_q   <= pkq_d;
      exp_q   <= exp_d;
      amin_q  <= amin_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hyst_d  = hyst_q;
    cnt_d   = cnt_q;
    xing_d  = xing_q;
    pki_d   = pki_q;
    pkq_d   = pkq_q;
    exp_d   = exp_q;
    amin_d  = amin_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (check_start) begin
          exp_d   = cfg_exp_xing;
          amin_d  = cfg_amp_min;
          xing_d  = '0;
          pki_d   = '0;
          pkq_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          hyst_d  = H_UNK;
          state_d = (SETTLE_LEN == 0) ? MEASURE : SETTLE;
        end
      end
      SETTLE: begin
        if (smp_v_q) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            hyst_d  = H_UNK;
            state_d = MEASURE;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      MEASURE: begin
        if (smp_v_q) begin
          if (mag_i > pki_q) pki_d = mag_i;
          if (mag_q > pkq_q) pkq_d = mag_q;
          if ($signed(smp_i_q) < HYST_N) begin
            hyst_d = H_NEG;
          end else if ($signed(smp_i_q) > HYST_P) begin
            hyst_d = H_POS;
            if (hyst_q == H_NEG && xing_q != 16'hFFFF) xing_d = xing_q + 16'd1;
          end
          if (cnt_q == WIN_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      default: begin
        pass_d  = verdict;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign check_busy   = busy_q;
  assign check_done   = done_q;
  assign check_pass   = pass_q;
  assign xing_count   = xing_q;
  assign peak_i       = pki_q;
  assign peak_q       = pkq_q;
  assign debug_signal = {13'd0, pass_q, state_q, pkq_q, pki_q, xing_q};

endmodule
`default_nettype wire

// File: doc/rx_tone_check_module.md
Name: rx_tone_check_module

Overview:
- Receive-side loopback checker for the dual-tone DAC test stream.
- Takes ADC I/Q samples at the 25 Msps sample clock, discards a settling interval, then measures over a fixed window:
  - rising zero crossings of I, using hysteresis;
  - peak magnitude of I and of Q.
- Issues a pass/fail verdict against the configured expected crossing count and minimum amplitude.
- Sits after the ADC interface. Results go to the MIF status registers and the debug bus.

Parameters:
WIN_LEN, 25000, number of valid samples in the measurement window (1 ms at 25 Msps); range 1..2^24-1
SETTLE_LEN, 16, valid samples discarded after start before measuring; 0 allowed
HYST, 512, hysteresis threshold for crossing detection (unsigned, <32768)
XING_TOL, 2, allowed absolute error between measured and expected crossing count

Ports:
clk_msk_in  input  1  sample clock
logic_rst_n_in  input  1  asynchronous active-low reset
rx_in_valid  input  1  sample qualifier; counters advance only on valid
rx_in_i  input  16  I sample, two's complement
rx_in_q  input  16  Q sample, two's complement
check_start  input  1  start pulse; sampled every cycle
cfg_exp_xing  input  16  expected rising-crossing count; captured at start
cfg_amp_min  input  16  minimum peak magnitude (unsigned); captured at start
check_busy  output  1  high from accepted start until DONE
check_done  output  1  one-cycle pulse when results are valid
check_pass  output  1  verdict; held until next accepted start
xing_count  output  16  measured rising crossings of I
peak_i  output  16  max |I| in window
peak_q  output  16  max |Q| in window
debug_signal  output  64  [15:0] xing_count, [31:16] peak_i, [47:32] peak_q, [49:48] state, [50] check_pass, [63:51] 0

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE, all counters 0, hysteresis state UNKNOWN;
  - all outputs 0.
- States: IDLE -> SETTLE -> MEASURE -> DONE -> IDLE.
- IDLE:
  - check_start=1 captures cfg_exp_xing/cfg_amp_min.
  - It clears xing_count, peak_i, peak_q, check_pass and sets check_busy next cycle.
  - It goes to SETTLE, or to MEASURE if SETTLE_LEN=0.
- check_start outside IDLE is ignored; there is no restart.
- SETTLE: counts valid samples. The edge accepting the SETTLE_LEN-th sample enters MEASURE. Those samples are discarded. Hysteresis state is forced to UNKNOWN on entering MEASURE.
- MEASURE: every valid sample updates counters and peaks. Invalid cycles hold everything.
- Magnitude: |x| = x if x>=0, else -x. -32768 saturates to 32767. Peak registers keep the running max.
- Hysteresis crossing detector on I:
  - If I < -HYST, state becomes NEG.
  - If I > +HYST, the state becomes POS. When the prior state was NEG, xing_count increments.
  - UNKNOWN->POS does not count.
  - Samples within ±HYST leave the state unchanged.
- xing_count saturates at 16'hFFFF.
- The edge accepting the WIN_LEN-th MEASURE sample enters DONE.
- Latency: the input may be registered once internally. check_done pulses exactly 2 cycles after the accepting edge of the last window sample, with final xing_count/peak_i/peak_q/check_pass valid in that cycle. check_busy drops in the same cycle as check_done.
- Verdict: pass = (|xing_count - exp_xing| <= XING_TOL) AND (peak_i >= amp_min) AND (peak_q >= amp_min).
  - The difference is computed 17-bit signed; no wrap.
- DONE lasts 1 cycle, then IDLE. Results hold until the next accepted start.
- check_start in the DONE cycle is ignored. Start is accepted in IDLE the following cycle.
- Reset mid-operation aborts immediately to the reset values. No check_done is issued.

Test Plan:
- Pure tone, 1 MHz, I=16000·cos, Q=16000·sin, continuous valid, WIN_LEN=250, SETTLE_LEN=16, exp=10, amp_min=15000 -> xing_count=10, peak_i=16000, peak_q>=15960, check_pass=1, done 2 cycles after sample 265 accepted.
- Same stimulus with exp=14, XING_TOL=2 -> check_pass=0, counts unchanged.
- Zero input (all samples 0) -> xing_count=0, peaks 0, check_pass=0; UNKNOWN state never counts.
- Valid toggling 1-of-3 cycles with the same tone samples -> identical results to the continuous case; done occurs 3x later in cycles.
- Input rx_in_i=-32768 on one sample, else ±1000 square wave with HYST=512 -> peak_i=32767; each low->high transition counts; ±300 chatter between transitions adds no counts.
- check_start pulsed during MEASURE is ignored; reset asserted mid-MEASURE -> all outputs 0 asynchronously, no check_done; a fresh start after release completes normally.
